// File: rtl/reverb_pkg.sv
// rtl/reverb_pkg.sv - shared constants, state encoding and arithmetic helpers for the multi-comb reverb
package reverb_pkg;

    localparam int Q15_ONE = 32768;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_MIX,
        ST_OUT
    } state_e;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

    // Clamp a wide signed value into a w-bit two's complement range; caller truncates to w bits.
    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/reverb_delay_ram.sv
// rtl/reverb_delay_ram.sv - single-port delay line storage with registered read, shared by all combs
module reverb_delay_ram #(
    parameter int DEPTH = 10,
    parameter int AW    = 4,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Read-before-write: the write-back in WR must not disturb the sample just fetched.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/reverb_multicomb.sv
// rtl/reverb_multicomb.sv - time-multiplexed feedback comb bank with wet/dry mix and saturation
module reverb_multicomb
    import reverb_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int NUM_COMBS  = 5,
    parameter int BASE_DELAY = 3000,
    parameter int DELAY_STEP = 2000,
    parameter int WET_SHIFT  = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] din,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [15:0]       feedback,
    input  logic [15:0]              mix,
    input  logic                     bypass,
    input  logic                     flush,
    output logic signed [DATA_W-1:0] dout,
    output logic                     out_valid,
    output logic                     overrun
);

    localparam int TOTAL_DEPTH = NUM_COMBS * BASE_DELAY + DELAY_STEP * NUM_COMBS * (NUM_COMBS - 1) / 2;
    localparam int AW   = (clog2(TOTAL_DEPTH) < 1) ? 1 : clog2(TOTAL_DEPTH);
    localparam int KW   = (clog2(NUM_COMBS) < 1) ? 1 : clog2(NUM_COMBS);
    localparam int PW   = DATA_W + 16;
    localparam int MW   = DATA_W + 18;
    localparam int ACCW = DATA_W + 4;

    state_e                   state_q;
    logic [AW-1:0]            clr_addr_q;
    logic [AW-1:0]            ptr_q [NUM_COMBS];
    logic [KW-1:0]            k_q;
    logic signed [DATA_W-1:0] x_q;
    logic signed [DATA_W-1:0] dout_q;
    logic signed [15:0]       fb_q;
    logic [16:0]              mix_q;
    logic signed [ACCW-1:0]   acc_q;
    logic                     flush_pend_q;
    logic                     out_valid_q;
    logic                     overrun_q;

    logic [AW-1:0]            base_sel;
    logic [AW-1:0]            last_sel;
    logic [AW-1:0]            ram_addr;
    logic                     ram_we;
    logic signed [DATA_W-1:0] ram_wdata;
    logic signed [DATA_W-1:0] ram_rdata;

    logic signed [PW-1:0]     fb_prod;
    logic signed [PW:0]       fb_sum;
    logic signed [DATA_W-1:0] wr_val;
    logic signed [ACCW-1:0]   acc_d;
    logic signed [DATA_W-1:0] wet;
    logic signed [17:0]       dry_gain;
    logic signed [17:0]       wet_gain;
    logic signed [MW-1:0]     dry_prod;
    logic signed [MW-1:0]     wet_prod;
    logic signed [MW:0]       mix_sum;
    logic signed [DATA_W-1:0] y_d;

    // Each comb owns a contiguous region of the RAM starting at its base offset.
    always_comb begin
        base_sel = '0;
        last_sel = '0;
        for (int i = 0; i < NUM_COMBS; i++) begin
            if (k_q == KW'(i)) begin
                base_sel = AW'(i * BASE_DELAY + DELAY_STEP * i * (i - 1) / 2);
                last_sel = AW'(BASE_DELAY + i * DELAY_STEP - 1);
            end
        end
    end

    assign ram_addr  = (state_q == ST_CLEAR) ? clr_addr_q : base_sel + ptr_q[k_q];
    assign ram_we    = (state_q == ST_CLEAR) || (state_q == ST_WR);
    assign ram_wdata = (state_q == ST_CLEAR) ? '0 : wr_val;

    reverb_delay_ram #(
        .DEPTH (TOTAL_DEPTH),
        .AW    (AW),
        .DW    (DATA_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    assign fb_prod  = PW'(fb_q) * PW'(ram_rdata);
    assign fb_sum   = (PW + 1)'(x_q) + (PW + 1)'(fb_prod >>> 15);
    assign wr_val   = DATA_W'(sat(64'(fb_sum), DATA_W));
    assign acc_d    = acc_q + ACCW'(ram_rdata);

    assign wet      = DATA_W'(sat(64'(acc_q >>> WET_SHIFT), DATA_W));
    assign dry_gain = {1'b0, 17'(Q15_ONE) - mix_q};
    assign wet_gain = {1'b0, mix_q};
    assign dry_prod = MW'(x_q) * MW'(dry_gain);
    assign wet_prod = MW'(wet) * MW'(wet_gain);
    assign mix_sum  = (MW + 1)'(dry_prod) + (MW + 1)'(wet_prod);
    assign y_d      = DATA_W'(sat(64'(mix_sum >>> 15), DATA_W));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_CLEAR;
            clr_addr_q   <= '0;
            k_q          <= '0;
            x_q          <= '0;
            fb_q         <= '0;
            mix_q        <= '0;
            acc_q        <= '0;
            dout_q       <= '0;
            flush_pend_q <= 1'b0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < NUM_COMBS; i++) ptr_q[i] <= '0;
        end else begin
            out_valid_q <= (state_q == ST_OUT);
            overrun_q   <= in_valid && ((state_q != ST_IDLE) || flush || flush_pend_q);
            if (flush && (state_q != ST_IDLE)) flush_pend_q <= 1'b1;
            unique case (state_q)
                ST_CLEAR: begin
                    if (clr_addr_q == AW'(TOTAL_DEPTH - 1)) begin
                        clr_addr_q <= '0;
                        state_q    <= ST_IDLE;
                    end else begin
                        clr_addr_q <= clr_addr_q + AW'(1);
                    end
                end
                ST_IDLE: begin
                    if (flush || flush_pend_q) begin
                        flush_pend_q <= 1'b0;
                        state_q      <= ST_CLEAR;
                    end else if (in_valid) begin
                        x_q     <= din;
                        fb_q    <= feedback;
                        mix_q   <= (mix > 16'h8000) ? 17'(Q15_ONE) : {1'b0, mix};
                        k_q     <= '0;
                        acc_q   <= '0;
                        state_q <= ST_RD;
                    end
                end
                ST_RD: state_q <= ST_WR;
                ST_WR: begin
                    acc_q      <= acc_d;
                    ptr_q[k_q] <= (ptr_q[k_q] == last_sel) ? '0 : ptr_q[k_q] + AW'(1);
                    if (k_q == KW'(NUM_COMBS - 1)) begin
                        state_q <= ST_MIX;
                    end else begin
                        k_q     <= k_q + KW'(1);
                        state_q <= ST_RD;
                    end
                end
                ST_MIX: begin
                    dout_q  <= bypass ? x_q : y_d;
                    state_q <= ST_OUT;
                end
                ST_OUT: state_q <= ST_IDLE;
                default: state_q <= ST_CLEAR;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign dout      = dout_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_reverb_multicomb.sv
// tb/tb_reverb_multicomb.sv - scoreboard bench for reverb_multicomb with two combs of delay 4 and 6
module tb_reverb_multicomb;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [15:0] din;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] feedback;
    logic [15:0]        mix;
    logic               bypass;
    logic               flush;
    logic signed [15:0] dout;
    logic               out_valid;
    logic               overrun;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        longint val;
        int     acc;
    } exp_t;

    exp_t   sb_q[$];
    exp_t   cur;
    longint line_m [2][6];
    int     ptr_m  [2];

    reverb_multicomb #(
        .DATA_W     (16),
        .NUM_COMBS  (2),
        .BASE_DELAY (4),
        .DELAY_STEP (2),
        .WET_SHIFT  (0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .feedback  (feedback),
        .mix       (mix),
        .bypass    (bypass),
        .flush     (flush),
        .dout      (dout),
        .out_valid (out_valid),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint msat(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic void model_clear(input bit with_ptrs);
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 6; j++) line_m[k][j] = 0;
            if (with_ptrs) ptr_m[k] = 0;
        end
    endfunction

    function automatic longint model_step(input longint x, input longint fb, input longint m_in, input bit byp);
        longint acc, old, wet, m;
        acc = 0;
        m = (m_in > 32768) ? 32768 : m_in;
        for (int k = 0; k < 2; k++) begin
            old = line_m[k][ptr_m[k]];
            acc += old;
            line_m[k][ptr_m[k]] = msat(x + ((fb * old) >>> 15));
            ptr_m[k] = (ptr_m[k] + 1) % (4 + 2 * k);
        end
        wet = msat(acc);
        if (byp) return x;
        return msat((x * (32768 - m) + wet * m) >>> 15);
    endfunction

    always @(negedge clk) begin
        if (out_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                cur = sb_q.pop_front();
                check("dout", longint'(dout), cur.val);
                check("latency", cyc - cur.acc, 6);
            end
        end
    end

    task automatic send(input logic signed [15:0] d, input logic signed [15:0] fb,
                        input logic [15:0] m, input logic byp);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("in_ready_wait", in_ready, 1);
        din      = d;
        feedback = fb;
        mix      = m;
        bypass   = byp;
        in_valid = 1'b1;
        cur.val  = model_step(longint'(d), longint'(fb), longint'(m), byp);
        cur.acc  = cyc + 1;
        sb_q.push_back(cur);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic count_clear(output int n, output bit quiet);
        n = 0;
        quiet = 1'b1;
        while (!in_ready && n < 50) begin
            if (out_valid !== 1'b0 || dout !== 16'sd0) quiet = 1'b0;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb_q.size() != 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("drain", sb_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        bit quiet;
        reset = 1'b0; in_valid = 1'b0; din = '0; feedback = '0;
        mix = '0; bypass = 1'b0; flush = 1'b0;
        model_clear(1'b1);
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_dout", longint'(dout), 0);
        check("rst_overrun", overrun, 0);
        reset = 1'b1;
        count_clear(n, quiet);
        check("clear_len_after_reset", n, 10);
        check("clear_quiet", quiet, 1);

        // Impulse without feedback: echoes at n=4 and n=6 only
        send(16'sd16384, 16'sd0, 16'd32768, 1'b0);
        for (int i = 0; i < 7; i++) send(16'sd0, 16'sd0, 16'd32768, 1'b0);
        drain();

        // Impulse with feedback 0.5
        send(16'sd16384, 16'sd16384, 16'd32768, 1'b0);
        for (int i = 0; i < 15; i++) send(16'sd0, 16'sd16384, 16'd32768, 1'b0);
        drain();

        // Near-unity feedback drives the wet sum into saturation
        send(16'sd32767, 16'sd32767, 16'd32768, 1'b0);
        for (int i = 0; i < 12; i++) send(16'sd0, 16'sd32767, 16'd32768, 1'b0);
        drain();

        // Dry-only mix passes din, including the negative extreme
        send(-16'sd32768, 16'sd0, 16'd0, 1'b0);
        send(16'sd32767, 16'sd0, 16'd0, 1'b0);
        send(16'sd1234, 16'sd0, 16'd0, 1'b0);
        send(16'sd5000, 16'sd0, 16'd40000, 1'b0);
        send(-16'sd700, 16'sd8192, 16'd16384, 1'b0);
        drain();

        send(16'sd3000, 16'sd16384, 16'd16384, 1'b1);
        send(-16'sd32768, 16'sd16384, 16'd32768, 1'b1);
        send(16'sd0, 16'sd16384, 16'd32768, 1'b1);
        drain();

        // Sample offered while busy is dropped with a single overrun pulse
        send(16'sd2000, 16'sd0, 16'd32768, 1'b0);
        @(negedge clk);
        din = 16'sd12345;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("overrun_busy", overrun, 1);
        @(negedge clk);
        check("overrun_single", overrun, 0);
        send(16'sd0, 16'sd0, 16'd32768, 1'b0);
        drain();

        // Flush with a simultaneous sample in IDLE: flush wins
        send(16'sd16384, 16'sd30000, 16'd32768, 1'b0);
        drain();
        flush = 1'b1;
        in_valid = 1'b1;
        din = 16'sd9999;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        check("overrun_flush", overrun, 1);
        model_clear(1'b0);
        count_clear(n, quiet);
        check("clear_len_after_flush", n, 10);
        for (int i = 0; i < 14; i++) send(16'sd0, 16'sd30000, 16'd32768, 1'b0);
        drain();

        // Reset asserted during WR of comb 1
        send(16'sd16384, 16'sd16384, 16'd32768, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        sb_q.delete();
        model_clear(1'b1);
        repeat (2) @(negedge clk);
        check("midrun_out_valid", out_valid, 0);
        check("midrun_dout", longint'(dout), 0);
        reset = 1'b1;
        count_clear(n, quiet);
        check("clear_len_after_midrun", n, 10);
        send(16'sd16384, 16'sd0, 16'd32768, 1'b0);
        for (int i = 0; i < 7; i++) send(16'sd0, 16'sd0, 16'd32768, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: observed no completion expected finish before 400000");
        $fatal(1, "timeout");
    end

endmodule
